// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard scoreboard unit.
package hazard_pkg;

    // Forward-select encodings for the EX-stage operand muxes
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    // Flush counter width (FLUSH_CYC <= 3) and MD outstanding count width (MD_MAX <= 7)
    localparam int unsigned FCW  = 2;
    localparam int unsigned MDCW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle; master is the pipeline, slave is the unit.
interface hazard_scoreboard_unit_if #(
    parameter int unsigned RW  = 5,
    parameter int unsigned SCW = 16
);
    logic [RW-1:0]  id_rs, id_rt, id_rd;
    logic           id_use_rs, id_use_rt, id_md;
    logic           idex_memread;
    logic [RW-1:0]  idex_rt, idex_rs_f, idex_rt_f;
    logic           exmem_regwrite, memwb_regwrite;
    logic [RW-1:0]  exmem_rd, memwb_rd;
    logic           br_taken;
    logic           md_done;
    logic [RW-1:0]  md_rd;
    logic           pc_write, ifid_write, idex_bubble, ifid_flush;
    logic [1:0]     fwd_a, fwd_b;
    logic           md_busy;
    logic [SCW-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_md,
               idex_memread, idex_rt, idex_rs_f, idex_rt_f,
               exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
               br_taken, md_done, md_rd,
        input  pc_write, ifid_write, idex_bubble, ifid_flush,
               fwd_a, fwd_b, md_busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_md,
               idex_memread, idex_rt, idex_rs_f, idex_rt_f,
               exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
               br_taken, md_done, md_rd,
        output pc_write, ifid_write, idex_bubble, ifid_flush,
               fwd_a, fwd_b, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_sb.sv
// Register scoreboard and outstanding-count tracker for multi-cycle MD operations.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned RW     = 5,
    parameter int unsigned MD_MAX = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [RW-1:0] issue_rd,
    input  logic          done,
    input  logic [RW-1:0] done_rd,
    input  logic [RW-1:0] look_a,
    input  logic [RW-1:0] look_b,
    input  logic [RW-1:0] look_c,
    output logic          busy_a,
    output logic          busy_b,
    output logic          busy_c,
    output logic          md_busy
);

    logic [NREG-1:0] sb_q, sb_d;
    logic [MDCW-1:0] cnt_q, cnt_d;

    // Next scoreboard/count: done clears, issue sets; a spurious done never underflows
    always_comb begin
        sb_d  = sb_q;
        cnt_d = cnt_q;
        if (done) begin
            sb_d[done_rd] = 1'b0;
        end
        if (issue && (issue_rd != '0)) begin
            sb_d[issue_rd] = 1'b1;
        end
        if (issue && !done) begin
            cnt_d = cnt_q + MDCW'(1);
        end else if (!issue && done && (cnt_q != '0)) begin
            cnt_d = cnt_q - MDCW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy_a  = sb_q[look_a];
    assign busy_b  = sb_q[look_b];
    assign busy_c  = sb_q[look_c];
    assign md_busy = (cnt_q == MDCW'(MD_MAX));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Stateful hazard controller: forwarding, load-use/MD stalls, flush sequencing, stall counter.
// Optional feature macro: HAZARD_MD_EN enables the MD scoreboard and structural/RAW/WAW stalls.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned NREG      = 32,
    parameter int unsigned RW        = $clog2(NREG),
    parameter int unsigned MD_MAX    = 2,
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned SCW       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_scoreboard_unit_if.slave  hif
);

    flush_state_t   state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [SCW-1:0] stall_cnt_q;
    logic [1:0]     fwd_a_c, fwd_b_c;
    logic           load_use, sb_haz, struct_haz, sb_full, stall, flush_act;
    logic           pc_write_c;

    // EX-stage operand forwarding, EX/MEM taking priority over MEM/WB
    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        if (hif.memwb_regwrite && (hif.memwb_rd != '0) && (hif.memwb_rd == hif.idex_rs_f)) fwd_a_c = FWD_WB;
        if (hif.memwb_regwrite && (hif.memwb_rd != '0) && (hif.memwb_rd == hif.idex_rt_f)) fwd_b_c = FWD_WB;
        if (hif.exmem_regwrite && (hif.exmem_rd != '0) && (hif.exmem_rd == hif.idex_rs_f)) fwd_a_c = FWD_MEM;
        if (hif.exmem_regwrite && (hif.exmem_rd != '0) && (hif.exmem_rd == hif.idex_rt_f)) fwd_b_c = FWD_MEM;
    end

    assign load_use = hif.idex_memread && (hif.idex_rt != '0) &&
                      ((hif.id_use_rs && (hif.idex_rt == hif.id_rs)) ||
                       (hif.id_use_rt && (hif.idex_rt == hif.id_rt)));

    assign flush_act = hif.br_taken || (state_q == FLUSH);
    assign stall     = load_use || sb_haz || struct_haz;

`ifdef HAZARD_MD_EN
    logic busy_rs, busy_rt, busy_rd, md_issue;

    assign md_issue = hif.id_md && !stall && !flush_act;

    hazard_sb #(
        .NREG   (NREG),
        .RW     (RW),
        .MD_MAX (MD_MAX)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .issue    (md_issue),
        .issue_rd (hif.id_rd),
        .done     (hif.md_done),
        .done_rd  (hif.md_rd),
        .look_a   (hif.id_rs),
        .look_b   (hif.id_rt),
        .look_c   (hif.id_rd),
        .busy_a   (busy_rs),
        .busy_b   (busy_rt),
        .busy_c   (busy_rd),
        .md_busy  (sb_full)
    );

    assign sb_haz     = (hif.id_use_rs && busy_rs) || (hif.id_use_rt && busy_rt) ||
                        (hif.id_md && busy_rd);
    assign struct_haz = hif.id_md && sb_full;
`else
    logic unused_md;

    assign unused_md  = ^{hif.id_md, hif.md_done, hif.md_rd, hif.id_rd};
    assign sb_haz     = 1'b0;
    assign struct_haz = 1'b0;
    assign sb_full    = 1'b0;
`endif

    // Flush FSM next state: FLUSH holds for the FLUSH_CYC-1 cycles after the branch cycle
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (hif.br_taken && (FLUSH_CYC > 1)) begin
                    state_d = FLUSH;
                    fcnt_d  = FCW'(FLUSH_CYC - 1);
                end
            end
            FLUSH: begin
                if (hif.br_taken) begin
                    fcnt_d = FCW'(FLUSH_CYC - 1);
                end else if (fcnt_q <= FCW'(1)) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - FCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    // Flush FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Pipeline controls; flush overrides stall, reset forces the idle values
    always_comb begin
        pc_write_c      = 1'b1;
        hif.ifid_write  = 1'b1;
        hif.idex_bubble = 1'b0;
        hif.ifid_flush  = 1'b0;
        hif.fwd_a       = FWD_RF;
        hif.fwd_b       = FWD_RF;
        hif.md_busy     = 1'b0;
        if (rst) begin
            if (flush_act) begin
                hif.ifid_flush  = 1'b1;
                hif.idex_bubble = 1'b1;
            end else if (stall) begin
                pc_write_c      = 1'b0;
                hif.ifid_write  = 1'b0;
                hif.idex_bubble = 1'b1;
            end
            hif.fwd_a   = fwd_a_c;
            hif.fwd_b   = fwd_b_c;
            hif.md_busy = sb_full;
        end
    end

    assign hif.pc_write = pc_write_c;

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (!pc_write_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + SCW'(1);
        end
    end

    assign hif.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit (MD_MAX=2, FLUSH_CYC=2).
module tb_hazard_scoreboard_unit;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    hazard_scoreboard_unit_if #(.RW(5), .SCW(16)) hif ();

    hazard_scoreboard_unit #(
        .NREG      (32),
        .RW        (5),
        .MD_MAX    (2),
        .FLUSH_CYC (2),
        .SCW       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        hif.id_rs = '0; hif.id_rt = '0; hif.id_rd = '0;
        hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0; hif.id_md = 1'b0;
        hif.idex_memread = 1'b0; hif.idex_rt = '0; hif.idex_rs_f = '0; hif.idex_rt_f = '0;
        hif.exmem_regwrite = 1'b0; hif.memwb_regwrite = 1'b0;
        hif.exmem_rd = '0; hif.memwb_rd = '0;
        hif.br_taken = 1'b0; hif.md_done = 1'b0; hif.md_rd = '0;
    endtask

    // Advance to just after the next rising edge
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        next_cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        hif.idex_memread = 1'b1; hif.idex_rt = 5'd5; hif.id_rs = 5'd5; hif.id_use_rs = 1'b1;
        hif.br_taken = 1'b1; hif.exmem_regwrite = 1'b1; hif.exmem_rd = 5'd3; hif.idex_rs_f = 5'd3;
        next_cyc();
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL rst_pc_write got=%0b exp=1", hif.pc_write); end
        checks++; if (hif.ifid_write !== 1'b1) begin errors++; $display("FAIL rst_ifid_write got=%0b exp=1", hif.ifid_write); end
        checks++; if (hif.idex_bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble got=%0b exp=0", hif.idex_bubble); end
        checks++; if (hif.ifid_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%0b exp=0", hif.ifid_flush); end
        checks++; if (hif.fwd_a !== 2'd0) begin errors++; $display("FAIL rst_fwd_a got=%0d exp=0", hif.fwd_a); end
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy got=%0b exp=0", hif.md_busy); end
        checks++; if (hif.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", hif.stall_cnt); end
        clear_inputs();
        rst = 1'b1;
        next_cyc();
        #1;
        checks++; if (hif.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_idle_cnt got=%0d exp=0", hif.stall_cnt); end
    endtask

    task automatic test_forward();
        do_reset();
        hif.exmem_regwrite = 1'b1; hif.exmem_rd = 5'd3;
        hif.memwb_regwrite = 1'b1; hif.memwb_rd = 5'd3;
        hif.idex_rs_f = 5'd3; hif.idex_rt_f = 5'd3;
        #1;
        checks++; if (hif.fwd_a !== 2'd2) begin errors++; $display("FAIL fwd_prio_a got=%0d exp=2", hif.fwd_a); end
        checks++; if (hif.fwd_b !== 2'd2) begin errors++; $display("FAIL fwd_prio_b got=%0d exp=2", hif.fwd_b); end
        hif.exmem_regwrite = 1'b0;
        #1;
        checks++; if (hif.fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_wb_a got=%0d exp=1", hif.fwd_a); end
        hif.exmem_regwrite = 1'b1; hif.exmem_rd = 5'd7; hif.idex_rt_f = 5'd7;
        #1;
        checks++; if (hif.fwd_b !== 2'd2) begin errors++; $display("FAIL fwd_mem_b got=%0d exp=2", hif.fwd_b); end
        checks++; if (hif.fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_split_a got=%0d exp=1", hif.fwd_a); end
        hif.exmem_rd = 5'd0; hif.memwb_rd = 5'd0; hif.idex_rs_f = 5'd0; hif.idex_rt_f = 5'd0;
        #1;
        checks++; if (hif.fwd_a !== 2'd0) begin errors++; $display("FAIL fwd_r0_a got=%0d exp=0", hif.fwd_a); end
        checks++; if (hif.fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_r0_b got=%0d exp=0", hif.fwd_b); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        hif.idex_memread = 1'b1; hif.idex_rt = 5'd5; hif.id_rs = 5'd5; hif.id_use_rs = 1'b1;
        #1;
        checks++; if (hif.pc_write !== 1'b0) begin errors++; $display("FAIL lu_pc_write got=%0b exp=0", hif.pc_write); end
        checks++; if (hif.ifid_write !== 1'b0) begin errors++; $display("FAIL lu_ifid_write got=%0b exp=0", hif.ifid_write); end
        checks++; if (hif.idex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%0b exp=1", hif.idex_bubble); end
        checks++; if (hif.ifid_flush !== 1'b0) begin errors++; $display("FAIL lu_flush got=%0b exp=0", hif.ifid_flush); end
        next_cyc();
        hif.idex_memread = 1'b0;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL lu_release got=%0b exp=1", hif.pc_write); end
        checks++; if (hif.idex_bubble !== 1'b0) begin errors++; $display("FAIL lu_release_bubble got=%0b exp=0", hif.idex_bubble); end
        checks++; if (hif.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", hif.stall_cnt); end
        hif.idex_memread = 1'b1; hif.idex_rt = 5'd0; hif.id_rs = 5'd0;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL lu_r0 got=%0b exp=1", hif.pc_write); end
        hif.idex_rt = 5'd6; hif.id_rt = 5'd6; hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL lu_unused_rt got=%0b exp=1", hif.pc_write); end
        hif.id_use_rt = 1'b1;
        #1;
        checks++; if (hif.pc_write !== 1'b0) begin errors++; $display("FAIL lu_rt got=%0b exp=0", hif.pc_write); end
        clear_inputs();
        next_cyc();
        #1;
        checks++; if (hif.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold got=%0d exp=1", hif.stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        hif.idex_memread = 1'b1; hif.idex_rt = 5'd5; hif.id_rs = 5'd5; hif.id_use_rs = 1'b1;
        hif.br_taken = 1'b1;
        #1;
        checks++; if (hif.ifid_flush !== 1'b1) begin errors++; $display("FAIL fl_c0_flush got=%0b exp=1", hif.ifid_flush); end
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL fl_c0_pc_write got=%0b exp=1", hif.pc_write); end
        checks++; if (hif.ifid_write !== 1'b1) begin errors++; $display("FAIL fl_c0_ifid_write got=%0b exp=1", hif.ifid_write); end
        checks++; if (hif.idex_bubble !== 1'b1) begin errors++; $display("FAIL fl_c0_bubble got=%0b exp=1", hif.idex_bubble); end
        next_cyc();
        hif.br_taken = 1'b0;
        #1;
        checks++; if (hif.ifid_flush !== 1'b1) begin errors++; $display("FAIL fl_c1_flush got=%0b exp=1", hif.ifid_flush); end
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL fl_c1_pc_write got=%0b exp=1", hif.pc_write); end
        next_cyc();
        #1;
        checks++; if (hif.ifid_flush !== 1'b0) begin errors++; $display("FAIL fl_c2_flush got=%0b exp=0", hif.ifid_flush); end
        checks++; if (hif.pc_write !== 1'b0) begin errors++; $display("FAIL fl_c2_stall got=%0b exp=0", hif.pc_write); end
        checks++; if (hif.stall_cnt !== 16'd0) begin errors++; $display("FAIL fl_stall_cnt got=%0d exp=0", hif.stall_cnt); end
        clear_inputs();
    endtask

`ifdef HAZARD_MD_EN
    task automatic test_md_raw();
        do_reset();
        hif.id_md = 1'b1; hif.id_rd = 5'd8;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL raw_issue got=%0b exp=1", hif.pc_write); end
        next_cyc();
        hif.id_md = 1'b0; hif.id_rd = 5'd9; hif.id_rs = 5'd8; hif.id_use_rs = 1'b1;
        #1;
        checks++; if (hif.pc_write !== 1'b0) begin errors++; $display("FAIL raw_stall got=%0b exp=0", hif.pc_write); end
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL raw_md_busy got=%0b exp=0", hif.md_busy); end
        next_cyc();
        hif.md_done = 1'b1; hif.md_rd = 5'd8;
        #1;
        checks++; if (hif.pc_write !== 1'b0) begin errors++; $display("FAIL raw_no_bypass got=%0b exp=0", hif.pc_write); end
        next_cyc();
        hif.md_done = 1'b0;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL raw_release got=%0b exp=1", hif.pc_write); end
        checks++; if (hif.stall_cnt !== 16'd2) begin errors++; $display("FAIL raw_stall_cnt got=%0d exp=2", hif.stall_cnt); end
        clear_inputs();
    endtask

    task automatic test_structural();
        do_reset();
        hif.id_md = 1'b1; hif.id_rd = 5'd1;
        next_cyc();
        hif.id_rd = 5'd2;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL st_second_issue got=%0b exp=1", hif.pc_write); end
        next_cyc();
        hif.id_rd = 5'd3;
        #1;
        checks++; if (hif.md_busy !== 1'b1) begin errors++; $display("FAIL st_md_busy got=%0b exp=1", hif.md_busy); end
        checks++; if (hif.pc_write !== 1'b0) begin errors++; $display("FAIL st_stall got=%0b exp=0", hif.pc_write); end
        next_cyc();
        hif.md_done = 1'b1; hif.md_rd = 5'd1;
        #1;
        checks++; if (hif.pc_write !== 1'b0) begin errors++; $display("FAIL st_done_cycle got=%0b exp=0", hif.pc_write); end
        next_cyc();
        hif.md_done = 1'b0;
        #1;
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL st_after_done_busy got=%0b exp=0", hif.md_busy); end
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL st_issue_next got=%0b exp=1", hif.pc_write); end
        next_cyc();
        hif.id_md = 1'b0;
        #1;
        checks++; if (hif.md_busy !== 1'b1) begin errors++; $display("FAIL st_refill_busy got=%0b exp=1", hif.md_busy); end
        hif.md_done = 1'b1; hif.md_rd = 5'd2;
        next_cyc();
        hif.id_md = 1'b1; hif.id_rd = 5'd5; hif.md_rd = 5'd3;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL st_simul_issue got=%0b exp=1", hif.pc_write); end
        next_cyc();
        clear_inputs();
        #1;
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL st_simul_count got=%0b exp=0", hif.md_busy); end
        hif.id_rs = 5'd5; hif.id_use_rs = 1'b1;
        #1;
        checks++; if (hif.pc_write !== 1'b0) begin errors++; $display("FAIL st_set_r5 got=%0b exp=0", hif.pc_write); end
        hif.id_rs = 5'd3;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL st_clear_r3 got=%0b exp=1", hif.pc_write); end
        hif.id_use_rs = 1'b0; hif.id_md = 1'b1; hif.id_rd = 5'd5;
        #1;
        checks++; if (hif.pc_write !== 1'b0) begin errors++; $display("FAIL st_waw got=%0b exp=0", hif.pc_write); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        hif.id_md = 1'b1; hif.id_rd = 5'd8;
        next_cyc();
        hif.id_rd = 5'd9;
        next_cyc();
        clear_inputs();
        #1;
        checks++; if (hif.md_busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got=%0b exp=1", hif.md_busy); end
        rst = 1'b0;
        #1;
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL rm_busy_in_rst got=%0b exp=0", hif.md_busy); end
        next_cyc();
        rst = 1'b1;
        hif.id_rs = 5'd8; hif.id_use_rs = 1'b1; hif.md_done = 1'b1; hif.md_rd = 5'd8;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL rm_sb_cleared got=%0b exp=1", hif.pc_write); end
        next_cyc();
        clear_inputs();
        hif.id_md = 1'b1; hif.id_rd = 5'd10;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL rm_issue1 got=%0b exp=1", hif.pc_write); end
        next_cyc();
        hif.id_rd = 5'd11;
        #1;
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL rm_count_one got=%0b exp=0", hif.md_busy); end
        next_cyc();
        clear_inputs();
        #1;
        checks++; if (hif.md_busy !== 1'b1) begin errors++; $display("FAIL rm_count_two got=%0b exp=1", hif.md_busy); end
        checks++; if (hif.stall_cnt !== 16'd0) begin errors++; $display("FAIL rm_stall_cnt got=%0d exp=0", hif.stall_cnt); end
    endtask
`else
    task automatic test_md_disabled();
        do_reset();
        hif.id_md = 1'b1; hif.id_rd = 5'd8;
        next_cyc();
        hif.id_rd = 5'd9;
        next_cyc();
        hif.id_rd = 5'd10;
        #1;
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL mdoff_busy got=%0b exp=0", hif.md_busy); end
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL mdoff_no_struct got=%0b exp=1", hif.pc_write); end
        hif.id_md = 1'b0; hif.id_rs = 5'd8; hif.id_use_rs = 1'b1;
        #1;
        checks++; if (hif.pc_write !== 1'b1) begin errors++; $display("FAIL mdoff_no_raw got=%0b exp=1", hif.pc_write); end
        next_cyc();
        clear_inputs();
        #1;
        checks++; if (hif.stall_cnt !== 16'd0) begin errors++; $display("FAIL mdoff_stall_cnt got=%0d exp=0", hif.stall_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_flush();
`ifdef HAZARD_MD_EN
        test_md_raw();
        test_structural();
        test_reset_mid();
`else
        test_md_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Pipeline hazard controller for the five-stage MIPS core, replacing the purely combinational forwarding and load-use detection with a parametrised, stateful unit. It tracks pending writes from a variable-latency multiply/divide unit in a register scoreboard, limits outstanding MD operations, and sequences multi-cycle control-hazard flushes. It also keeps a saturating stall-cycle performance counter. It sits beside the controller and drives PC/IF-ID enables, the ID/EX bubble, the IF/ID flush and the EX-stage forwarding muxes.

## Interface
Parameters:
- NREG, 32, architectural register count; register 0 is hardwired zero.
- RW, $clog2(NREG), register index width.
- MD_MAX, 2, maximum outstanding multi-cycle operations (1..7).
- FLUSH_CYC, 1, IF/ID flush cycles after a taken branch or jump (1..3).
- SCW, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  RW  ID-stage source registers.
- id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt.
- id_rd  in  RW  ID-stage destination register.
- id_md  in  1  ID instruction is a multi-cycle MD op writing id_rd.
- idex_memread  in  1  EX-stage instruction is a load.
- idex_rt  in  RW  load destination in EX.
- idex_rs_f, idex_rt_f  in  RW  EX-stage source registers, used for forwarding.
- exmem_regwrite, memwb_regwrite  in  1  stage write enables.
- exmem_rd, memwb_rd  in  RW  stage destinations.
- br_taken  in  1  EX resolved a taken branch, j, jr or jal.
- md_done  in  1  MD result written back this cycle.
- md_rd  in  RW  register written by md_done.
- pc_write, ifid_write  out  1  stage enables.
- idex_bubble  out  1  zero the ID/EX control word.
- ifid_flush  out  1  squash the IF/ID register.
- fwd_a, fwd_b  out  2  forward select: 0 regfile, 1 MEM/WB, 2 EX/MEM.
- md_busy  out  1  outstanding count equals MD_MAX.
- stall_cnt  out  SCW  stall-cycle counter.

## Operation
- Forwarding is combinational. EX/MEM wins over MEM/WB. A match requires regwrite=1 and rd≠0.
- **Load-use hazard:** idex_memread=1 and idex_rt≠0, and idex_rt matches a used ID source.
- **Scoreboard hazard:** the scoreboard bit is set for a used ID source (RAW), or for id_rd when id_md=1 (WAW).
- **Structural hazard:** id_md=1 and the outstanding count equals MD_MAX.
- **Stall:** any of the three hazards above. During a stall, pc_write=0, ifid_write=0 and idex_bubble=1.
- **Issue:** id_md=1 with no stall and no flush. On issue, the scoreboard bit for id_rd is set, unless id_rd=0, and the outstanding count increments.
- **md_done:** clears the scoreboard bit for md_rd and decrements the count. The count saturates at 0; a spurious done is ignored.
- **Simultaneous issue and done:** the count is unchanged, and the set and clear apply to their own registers.
- **No bypass:** a stall caused by a bit that md_done clears this cycle still holds this cycle and releases the next.
- **Flush state machine:**
  - IDLE: on br_taken, go to FLUSH with fcnt=FLUSH_CYC-1.
  - FLUSH: decrement fcnt and return to IDLE at 0. A new br_taken reloads fcnt.
  - ifid_flush=1 in any cycle with br_taken=1 or state FLUSH.
- **Flush overrides stall:** while flushing, pc_write=1, ifid_write=1 and idex_bubble=1, and no issue occurs.
- **stall_cnt:** increments in each cycle with pc_write=0 and saturates at all-ones.

## Timing
- All hazard and forward outputs are combinational from the inputs and registered state, with zero-cycle latency.
- Scoreboard, count, flush state and stall_cnt update on the rising clk edge.
- A load-use stall lasts exactly 1 cycle.
- A scoreboard stall ends in the cycle after md_done.
- While rst=0:
  - All state clears asynchronously: scoreboard=0, count=0, IDLE, stall_cnt=0.
  - Outputs are forced to pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, fwd_a=fwd_b=0 and md_busy=0.
- Reset asserted mid-operation discards all pending MD tracking. A later md_done is ignored by the saturating count.

## Configuration
- HAZARD_MD_EN defined: the scoreboard, the outstanding count and the MD structural/RAW/WAW stalls are present.
- HAZARD_MD_EN undefined:
  - id_md, md_done and md_rd are ignored, and md_busy=0.
  - Only load-use stall, flush and forwarding remain.
  - The unit behaves as a load-use-only hazard unit plus flush and counter.

## Structure
- Package hazard_pkg holds:
  - the forward-select constants FWD_RF=0, FWD_WB=1, FWD_MEM=2;
  - the flush-state enum (IDLE, FLUSH).
- Sub-module hazard_sb holds the NREG-bit scoreboard and the outstanding count. Its outputs are busy-lookup for three indices and md_busy. It is instantiated only under HAZARD_MD_EN.

## Test plan
- **Load-use:** lw to r5 in EX; ID add reads r5 -> exactly one cycle of pc_write=0, idex_bubble=1, stall_cnt=1.
- **Forward priority:** exmem_rd=memwb_rd=r3, both regwrite=1, idex_rs_f=r3 -> fwd_a=2. Same case with rd=r0 -> fwd_a=0.
- **MD RAW:** issue div to r8; next instruction reads r8 -> stall until the cycle after md_done with md_rd=8, then release.
- **Structural:** MD_MAX=2; issue two MD ops, then a third -> md_busy=1 and a stall. md_done -> issue occurs the next cycle.
- **Flush:** FLUSH_CYC=2, br_taken for one cycle during a load-use stall -> ifid_flush=1 for 2 cycles, pc_write=1 throughout.
- **Reset mid-operation:** rst=0 with 2 outstanding MD ops -> scoreboard and count are 0. A following md_done leaves the count at 0 with no stall.
